// File: rtl/as_nibble_sequencer.sv
// Two-requester front end that time-shares one external 4-bit adder/subtractor,
// walking W-bit operands one nibble per cycle, least significant nibble first.
module as_nibble_sequencer #(
    parameter int unsigned NIB = 4,
    localparam int unsigned W = 4 * NIB
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_sub,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_sub,
    output logic [3:0]   as_A,
    output logic [3:0]   as_B,
    output logic         as_M,
    output logic         as_cin,
    input  logic [3:0]   as_S,
    input  logic         as_Cout,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_sum,
    output logic         rsp_cout,
    output logic         rsp_ovf
);

    localparam int unsigned IW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t        state;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [W-1:0]  result;
    logic          op_sub;
    logic          owner;
    logic          last;
    logic          carry;
    logic [IW-1:0] idx;
    logic          grant0;
    logic          grant1;
    logic          run;

    // last = 1 means req1 was granted most recently, so req0 wins a tie.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last);
        grant1 = req1_valid && (!req0_valid || !last);
    end

    assign run        = (state == StRun);
    assign req0_ready = (state == StIdle) && !rst && grant0;
    assign req1_ready = (state == StIdle) && !rst && grant1;

    assign as_A   = run ? op_a[4*idx +: 4] : 4'h0;
    assign as_B   = run ? op_b[4*idx +: 4] : 4'h0;
    assign as_M   = run && op_sub;
    assign as_cin = run && ((idx == '0) ? op_sub : carry);

    assign rsp_valid = (state == StDone);
    assign rsp_id    = owner;
    assign rsp_sum   = result;
    assign rsp_cout  = carry;
    assign rsp_ovf   = (op_a[W-1] == (op_b[W-1] ^ op_sub)) && (result[W-1] != op_a[W-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= StIdle;
            op_a   <= '0;
            op_b   <= '0;
            op_sub <= 1'b0;
            owner  <= 1'b0;
            last   <= 1'b1;
            idx    <= '0;
            result <= '0;
            carry  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (grant0 || grant1) begin
                        op_a   <= grant1 ? req1_a : req0_a;
                        op_b   <= grant1 ? req1_b : req0_b;
                        op_sub <= grant1 ? req1_sub : req0_sub;
                        owner  <= grant1;
                        last   <= grant1;
                        idx    <= '0;
                        state  <= StRun;
                    end
                end
                StRun: begin
                    result[4*idx +: 4] <= as_S;
                    carry              <= as_Cout;
                    if (idx == IW'(NIB - 1)) begin
                        state <= StDone;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                StDone: begin
                    if (rsp_ready) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_as_nibble_sequencer.sv
// Scoreboard bench for as_nibble_sequencer: an acceptance monitor queues expected results,
// a response monitor pops and compares them; the adder/subtractor is modelled here.
module tb_as_nibble_sequencer;

    localparam int NIB = 4;
    localparam int W   = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req0_sub;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_sub;
    logic [W-1:0] req1_a, req1_b;
    logic [3:0]   as_A, as_B, as_S;
    logic         as_M, as_cin, as_Cout;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf;
    logic [W-1:0] rsp_sum;
    logic [4:0]   dp;

    as_nibble_sequencer #(.NIB(NIB)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .as_A       (as_A),
        .as_B       (as_B),
        .as_M       (as_M),
        .as_cin     (as_cin),
        .as_S       (as_S),
        .as_Cout    (as_Cout),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_ovf    (rsp_ovf)
    );

    always #5 clk = ~clk;

    // Shared combinational 4-bit adder/subtractor.
    assign dp      = {1'b0, as_A} + {1'b0, as_B ^ {4{as_M}}} + {4'b0, as_cin};
    assign as_S    = dp[3:0];
    assign as_Cout = dp[4];

    typedef struct packed {
        logic        id;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic [31:0] acc;
    } exp_t;

    exp_t        sb[$];
    logic        grant_q[$];
    logic [17:0] exp0, exp1;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_rsp_cyc = 0;
    logic        rr_mode = 1'b0;
    logic        prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Acceptance monitor: the accepting edge is the next rising edge, numbered cyc+1.
    always @(negedge clk) begin
        if (!rst) begin
            if (req0_ready && req1_ready) chk("both_ready", 1, 0);
            if (req0_valid && req0_ready) begin
                sb.push_back({1'b0, exp0, cyc + 1});
                if (grant_q.size() > 0) chk("grant_id", 0, grant_q.pop_front());
                if (rr_mode) chk("grant_gap", cyc + 1 - last_rsp_cyc, 2);
            end
            if (req1_valid && req1_ready) begin
                sb.push_back({1'b1, exp1, cyc + 1});
                if (grant_q.size() > 0) chk("grant_id", 1, grant_q.pop_front());
                if (rr_mode) chk("grant_gap", cyc + 1 - last_rsp_cyc, 2);
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        prev_valid <= rsp_valid;
        if (!rst) begin
            if (rsp_valid && !prev_valid) begin
                if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
                else chk("latency", cyc - sb[0].acc, NIB);
            end
            if (rsp_valid && rsp_ready && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_sum", rsp_sum, e.sum);
                chk("rsp_cout", rsp_cout, e.cout);
                chk("rsp_ovf", rsp_ovf, e.ovf);
                last_rsp_cyc <= cyc;
            end
        end
    end

    task automatic set_req(input bit n, input logic [15:0] a, input logic [15:0] b,
                           input logic sub, input logic [15:0] s, input logic c, input logic o);
        if (n == 1'b0) begin
            req0_a = a; req0_b = b; req0_sub = sub; exp0 = {s, c, o}; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_sub = sub; exp1 = {s, c, o}; req1_valid = 1'b1;
        end
    endtask

    // Present one request, wait for its grant, then drop it and scramble the operands.
    task automatic issue(input bit n, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic [15:0] s, input logic c, input logic o);
        int  i;
        logic got;
        set_req(n, a, b, sub, s, c, o);
        i = 0;
        got = 1'b0;
        while (!got && i < 50) begin
            @(negedge clk);
            got = n ? req1_ready : req0_ready;
            i++;
        end
        if (!got) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (n == 1'b0) begin
            req0_valid = 1'b0; req0_a = 16'($urandom); req0_b = 16'($urandom); req0_sub = ~sub;
        end else begin
            req1_valid = 1'b0; req1_a = 16'($urandom); req1_b = 16'($urandom); req1_sub = ~sub;
        end
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while ((sb.size() != 0 || rsp_valid) && i < 100) begin
            @(negedge clk);
            i++;
        end
        if (i >= 100) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grants();
        int i;
        i = 0;
        while (grant_q.size() != 0 && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (i >= 200) chk("grant_timeout", 0, 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        exp0 = '0;
        exp1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_as_A", as_A, 0);
        chk("rst_ready", {req0_ready, req1_ready}, 0);
        rst = 1'b0;

        issue(0, 16'h1234, 16'h0FFF, 0, 16'h2233, 0, 0);
        wait_idle();
        issue(1, 16'h0005, 16'h0007, 1, 16'hFFFE, 0, 0);
        wait_idle();
        issue(1, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0);
        wait_idle();
        issue(0, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1);
        wait_idle();
        issue(1, 16'h8000, 16'h0001, 1, 16'h7FFF, 1, 1);
        wait_idle();

        // Both requesters held valid: grants alternate, starting with req0.
        grant_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        set_req(0, 16'h1234, 16'h0FFF, 0, 16'h2233, 0, 0);
        set_req(1, 16'h8000, 16'h0001, 1, 16'h7FFF, 1, 1);
        for (int i = 0; i < 20 && grant_q.size() == 4; i++) @(negedge clk);
        rr_mode = 1'b1;
        wait_grants();
        rr_mode = 1'b0;
        wait_idle();

        // Consumer stalls for 10 cycles in DONE while req1 waits.
        rsp_ready = 1'b0;
        issue(0, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1);
        set_req(1, 16'h0005, 16'h0007, 1, 16'hFFFE, 0, 0);
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_sum", rsp_sum, 16'h8000);
            chk("hold_flags", {rsp_id, rsp_cout, rsp_ovf}, 3'b001);
            chk("hold_no_ready", {req0_ready, req1_ready}, 0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("handshake_no_ready", req1_ready, 0);
        @(negedge clk);
        chk("after_hs_valid", rsp_valid, 0);
        chk("after_hs_ready", req1_ready, 1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        wait_idle();

        // Reset mid-operation during nibble 2.
        issue(1, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("n2_as_A", as_A, 4'hF);
        chk("n2_as_B", as_B, 4'h0);
        chk("n2_as_cin", as_cin, 1);
        set_req(0, 16'h1234, 16'h0FFF, 0, 16'h2233, 0, 0);
        set_req(1, 16'h0005, 16'h0007, 1, 16'hFFFE, 0, 0);
        rst = 1'b1;
        #1;
        chk("arst_valid", rsp_valid, 0);
        chk("arst_sum", rsp_sum, 0);
        chk("arst_dp", {as_A, as_B, as_M, as_cin}, 0);
        chk("arst_ready", {req0_ready, req1_ready}, 0);
        chk("arst_flags", {rsp_id, rsp_cout, rsp_ovf}, 0);
        chk("arst_pending", sb.size(), 1);
        void'(sb.pop_front());
        grant_q = '{1'b0, 1'b1};
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_grants();
        wait_idle();
        repeat (5) @(posedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/as_nibble_sequencer.md
AS_NIBBLE_SEQUENCER -- requirements
Module: as_nibble_sequencer

Interface
REQ-001 Parameter: NIB, 4, number of 4-bit nibbles per operand; operand width W = 4*NIB (16 at default).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 reqN_valid  input  1  (N=0,1) requester N has an operation pending.
REQ-006 reqN_ready  output  1  (N=0,1) operation accepted this cycle.
REQ-007 reqN_a, reqN_b  input  W  (N=0,1) operands.
REQ-008 reqN_sub  input  1  (N=0,1) 0 = a+b, 1 = a-b.
REQ-009 as_A, as_B  output  4  nibble operands to the shared 4-bit adder/subtractor.
REQ-010 as_M  output  1  mode to the datapath: 0 = add, 1 = subtract (B inverted).
REQ-011 as_cin  output  1  carry-in to the datapath.
REQ-012 as_S  input  4  datapath sum; combinational, as_A + (as_B ^ {4{as_M}}) + as_cin in the same cycle.
REQ-013 as_Cout  input  1  datapath carry-out, same cycle.
REQ-014 rsp_valid  output  1  result available.
REQ-015 rsp_ready  input  1  consumer accepts the result.
REQ-016 rsp_id  output  1  index of the requester that owns the result.
REQ-017 rsp_sum  output  W  result.
REQ-018 rsp_cout  output  1  final carry (subtract: 1 = no borrow).
REQ-019 rsp_ovf  output  1  two's-complement signed overflow.

Function
REQ-020 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-021 IDLE: if any reqN_valid is high, exactly one reqN_ready SHALL be asserted combinationally in that cycle. Operands, sub and id latch on the edge, and the state becomes RUN with nibble index 0.
REQ-022 Arbitration SHALL be round-robin. With both valid, the requester not granted last wins; with one valid, that one wins.
REQ-023 reqN_ready SHALL be 0 in RUN and DONE.
REQ-024 RUN nibble k: as_A = a[4k+3:4k], as_B = b[4k+3:4k], as_M = sub. as_cin = sub for k=0, otherwise the registered as_Cout of nibble k-1.
REQ-025 Each RUN cycle SHALL capture as_S into result[4k+3:4k] and as_Cout into the carry register.
REQ-026 After nibble NIB-1 is captured, the state SHALL become DONE.
REQ-027 In IDLE and DONE, as_A, as_B, as_M and as_cin SHALL drive 0.
REQ-028 Latency: acceptance at edge T SHALL give rsp_valid high from edge T+NIB (4 cycles at default).
REQ-029 DONE: rsp_valid = 1. rsp_sum, rsp_cout, rsp_ovf and rsp_id SHALL stay stable until a cycle with rsp_ready = 1.
REQ-030 On that rsp_ready cycle the state SHALL return to IDLE. No new acceptance happens in that same cycle; the earliest next reqN_ready is the following cycle.
REQ-031 rsp_ovf SHALL equal (a[W-1] == b'[W-1]) && (sum[W-1] != a[W-1]), where b' = b ^ {W{sub}}.
REQ-032 rsp_cout SHALL equal the carry-out of nibble NIB-1.
REQ-033 Requester inputs changing after acceptance SHALL NOT affect the operation in progress.

Reset
REQ-034 On rst = 1 (any state, including mid-RUN), the block SHALL immediately enter IDLE with all outputs 0.
REQ-035 Reset SHALL also clear the operand, result and carry registers and set the round-robin pointer so that req1 counts as last granted (req0 wins the first tie).
REQ-036 Any operation in progress at reset SHALL be discarded without a response.

Verification
REQ-037 req0: a=0x1234, b=0x0FFF, sub=0 -> rsp_sum=0x2233, cout=0, ovf=0, id=0, rsp_valid exactly 4 cycles after acceptance.
REQ-038 req1: a=0x0005, b=0x0007, sub=1 -> rsp_sum=0xFFFE, cout=0, ovf=0; also 0xFFFF+0x0001 -> sum=0x0000, cout=1, ovf=0.
REQ-039 0x7FFF+0x0001 -> sum=0x8000, ovf=1; 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
REQ-040 Both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1, with each grant two cycles after the previous response.
REQ-041 rsp_ready held 0 for 10 cycles in DONE -> rsp_* held stable, no reqN_ready. rsp_ready=1 -> IDLE the next cycle.
REQ-042 rst pulsed during RUN nibble 2 -> outputs 0 immediately, no response. A subsequent request completes normally, and req0 wins the first tie.
